// File: rtl/reg_scan_engine.sv
// Bulk load/dump sequencer for the register file.
// Load: writes a contiguous register block from a valid/ready byte stream.
// Dump: reads a contiguous register block out over a registered valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start; samples Mode/BaseAddr/Count on Start
// LOAD    | accepting stream beats, one register write per beat
// DUMP    | streaming registers out; drains the output slot before DONE
// DONE    | one-cycle completion pulse, then back to IDLE
module reg_scan_engine #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Mode,
  input  logic [D-1:0] BaseAddr,
  input  logic [D:0]   Count,
  output logic         Busy,
  output logic         Done,
  input  logic [W-1:0] InData,
  input  logic         InValid,
  output logic         InReady,
  output logic [W-1:0] OutData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         RfWriteEn,
  output logic [D-1:0] RfWaddr,
  output logic [W-1:0] RfDataIn,
  output logic [D-1:0] RfRaddr,
  input  logic [W-1:0] RfDataOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};
  localparam logic [D:0] ONE  = {{D{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [D-1:0] ptr_q, ptr_d;
  logic [D:0]   remain_q, remain_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [D:0]   count_sat;
  logic         slot_free;

  assign count_sat = (Count > FULL) ? FULL : Count;
  assign slot_free = !out_valid_q || OutReady;

  assign RfWaddr  = ptr_q;
  assign RfRaddr  = ptr_q;
  assign RfDataIn = InData;
  assign OutData  = out_data_q;
  assign OutValid = out_valid_q;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, pointer/remaining-count updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    Busy        = 1'b0;
    Done        = 1'b0;
    InReady     = 1'b0;
    RfWriteEn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          ptr_d    = BaseAddr;
          remain_d = count_sat;
          if (count_sat == '0) state_d = ST_DONE;
          else if (Mode)       state_d = ST_DUMP;
          else                 state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        Busy      = 1'b1;
        InReady   = 1'b1;
        RfWriteEn = InValid;
        if (InValid) begin
          ptr_d    = ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == ONE) state_d = ST_DONE;
        end
      end
      ST_DUMP: begin
        Busy = 1'b1;
        if (slot_free) begin
          if (remain_q != '0) begin
            out_data_d  = RfDataOut;
            out_valid_d = 1'b1;
            ptr_d       = ptr_q + 1'b1;
            remain_d    = remain_q - 1'b1;
          end else begin
            // The last beat must leave the slot before completion is signalled.
            out_valid_d = 1'b0;
            if (!out_valid_q) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_scan_engine.sv
// Bench for reg_scan_engine: a register-file model plus a transaction-level
// scoreboard (expected writes / expected dump beats) and directed vectors.
module tb_reg_scan_engine;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         Clk = 1'b0;
  logic         Reset_n, Start, Mode, InValid, OutReady;
  logic [D-1:0] BaseAddr;
  logic [D:0]   Count;
  logic [W-1:0] InData;
  logic         Busy, Done, InReady, OutValid, RfWriteEn;
  logic [W-1:0] OutData, RfDataIn, RfDataOut;
  logic [D-1:0] RfWaddr, RfRaddr;

  reg_scan_engine #(.W(W), .D(D)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
    .BaseAddr(BaseAddr), .Count(Count), .Busy(Busy), .Done(Done),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .RfWriteEn(RfWriteEn), .RfWaddr(RfWaddr), .RfDataIn(RfDataIn),
    .RfRaddr(RfRaddr), .RfDataOut(RfDataOut)
  );

  always #5 Clk = ~Clk;

  // Register file: synchronous write, combinational read port A.
  logic [W-1:0] rf [N];
  assign RfDataOut = rf[RfRaddr];
  always @(posedge Clk) if (RfWriteEn === 1'b1) rf[RfWaddr] <= RfDataIn;

  int vectors = 0, miscompares = 0;
  logic [W-1:0] ref_mem [N];
  int exp_wa[$], exp_wd[$], exp_rd[$];
  int done_cnt = 0, hs_cnt = 0, wr_cnt = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard compare: writes, dump beats, stall stability, Done pulse width.
  logic         stall_prev = 1'b0, done_prev = 1'b0;
  logic [W-1:0] data_prev = '0;
  always @(negedge Clk) if (mon_en) begin
    if (RfWriteEn === 1'b1) begin
      wr_cnt++;
      if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_addr", RfWaddr, exp_wa.pop_front());
        chk("wr_data", RfDataIn, exp_wd.pop_front());
      end
    end
    if (stall_prev) begin
      chk("stall_valid", OutValid, 1);
      chk("stall_data", OutData, data_prev);
    end
    if (OutValid === 1'b1 && OutReady === 1'b1) begin
      hs_cnt++;
      if (exp_rd.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("beat_data", OutData, exp_rd.pop_front());
    end
    if (Done === 1'b1) begin
      done_cnt++;
      chk("done_single", done_prev, 0);
    end
    stall_prev = OutValid && !OutReady && Reset_n;
    data_prev  = OutData;
    done_prev  = Done;
  end

  task tick(); @(posedge Clk); #1; endtask
  task settle(); #1; endtask

  task automatic push_wr(input int a, input int d);
    exp_wa.push_back(a);
    exp_wd.push_back(d & 8'hFF);
    ref_mem[a] = d[W-1:0];
  endtask

  task automatic push_dump(input int base, input int n);
    for (int i = 0; i < n; i++) exp_rd.push_back(int'(ref_mem[(base + i) % N]));
  endtask

  task automatic start_op(input logic m, input int base, input int cnt);
    Mode = m; BaseAddr = base[D-1:0]; Count = cnt[D:0]; Start = 1'b1;
    tick();
    Start = 1'b0;
    settle();
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      if (Done === 1'b1) got = 1'b1;
      else tick();
    end
    chk(name, got, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_inready"}, InReady, 0);
    chk({tag, "_outvalid"}, OutValid, 0);
    chk({tag, "_outdata"}, OutData, 0);
    chk({tag, "_we"}, RfWriteEn, 0);
    chk({tag, "_waddr"}, RfWaddr, 0);
    chk({tag, "_raddr"}, RfRaddr, 0);
  endtask

  // Back-to-back load; expected writes come from the base/count/data rule.
  task automatic do_load(input string tag, input int base, input int cnt, input int d0, input int step);
    int n;
    n = (cnt > N) ? N : cnt;
    for (int i = 0; i < n; i++) push_wr((base + i) % N, d0 + step * i);
    start_op(1'b0, base, cnt);
    InValid = 1'b1;
    for (int i = 0; i < n; i++) begin
      InData = 8'((d0 + step * i) & 8'hFF);
      tick();
    end
    InValid = 1'b0;
    settle();
    chk({tag, "_done"}, Done, 1);
    tick();
    chk({tag, "_idle"}, Busy, 0);
    chk({tag, "_wr_left"}, exp_wa.size(), 0);
  endtask

  logic [4:0]   pat;
  logic [4:0]   gaps;
  logic [W-1:0] d4 [3];
  int           base_cnt, base_hs, base_wr, dix;

  initial begin
    Start = 0; Mode = 0; BaseAddr = '0; Count = '0; InData = '0;
    InValid = 0; OutReady = 0; Reset_n = 0;
    for (int i = 0; i < N; i++) begin rf[i] = '0; ref_mem[i] = '0; end
    repeat (2) tick();
    check_reset("rst");
    Reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Load base 2, count 3, back-to-back beats.
    push_wr(2, 8'hA1); push_wr(3, 8'hB2); push_wr(4, 8'hC3);
    start_op(1'b0, 2, 3);
    chk("t1_busy", Busy, 1);
    chk("t1_inready", InReady, 1);
    chk("t1_we_noval", RfWriteEn, 0);
    InValid = 1'b1; InData = 8'hA1; settle();
    chk("t1_we", RfWriteEn, 1);
    chk("t1_waddr0", RfWaddr, 4'd2);
    tick();
    InData = 8'hB2; tick();
    InData = 8'hC3; settle();
    chk("t1_waddr2", RfWaddr, 4'd4);
    tick();
    InValid = 1'b0; settle();
    chk("t1_done", Done, 1);
    tick();
    chk("t1_idle", Busy, 0);
    chk("t1_done_off", Done, 0);
    // Read back registers 2..4.
    push_dump(2, 3);
    OutReady = 1'b1;
    start_op(1'b1, 2, 3);
    wait_done("t1_rb_done", 12);
    tick();
    chk("t1_rb_left", exp_rd.size(), 0);

    // Preload r14..r1 with wrap, then dump base 14 count 4.
    do_load("t2_pre", 14, 4, 8'h0E, 1);
    push_dump(14, 4);
    OutReady = 1'b1;
    start_op(1'b1, 14, 4);
    chk("t2_busy", Busy, 1);
    chk("t2_inready", InReady, 0);
    chk("t2_ov_e0", OutValid, 0);
    tick(); chk("t2_ov1", OutValid, 1); chk("t2_d1", OutData, 8'h0E);
    tick(); chk("t2_d2", OutData, 8'h0F);
    tick(); chk("t2_d3", OutData, 8'h10);
    tick(); chk("t2_d4", OutData, 8'h11);
    tick(); chk("t2_ov_drain", OutValid, 0); chk("t2_done_early", Done, 0);
    tick(); chk("t2_done", Done, 1);
    tick(); chk("t2_idle", Busy, 0);

    // Dump count 3 with OutReady pattern 1,0,0,1,1.
    pat = 5'b11001;
    push_dump(2, 3);
    base_hs = hs_cnt; base_cnt = done_cnt;
    start_op(1'b1, 2, 3);
    for (int i = 0; i < 5; i++) begin OutReady = pat[i]; tick(); end
    OutReady = 1'b1;
    wait_done("t3_done", 12);
    tick();
    chk("t3_handshakes", hs_cnt - base_hs, 3);
    chk("t3_left", exp_rd.size(), 0);
    chk("t3_done_cnt", done_cnt - base_cnt, 1);

    // Load with InValid gaps 1,0,1,0,1; Start mid-load ignored.
    gaps = 5'b10101;
    d4[0] = 8'h31; d4[1] = 8'h42; d4[2] = 8'h53;
    for (int i = 0; i < 3; i++) push_wr(5 + i, d4[i]);
    base_wr = wr_cnt;
    start_op(1'b0, 5, 3);
    dix = 0;
    for (int i = 0; i < 5; i++) begin
      InValid = gaps[i];
      InData  = gaps[i] ? d4[dix] : 8'hEE;
      if (i == 1) begin Start = 1'b1; Mode = 1'b1; BaseAddr = 4'd9; Count = 5'd2; end
      settle();
      chk("t4_we", RfWriteEn, gaps[i]);
      tick();
      Start = 1'b0;
      if (gaps[i]) dix++;
    end
    InValid = 1'b0; settle();
    chk("t4_done", Done, 1);
    tick();
    chk("t4_idle", Busy, 0);
    chk("t4_writes", wr_cnt - base_wr, 3);

    // Count 0 (load and dump), then Count 20 saturating to 16.
    base_wr = wr_cnt;
    do_load("t5_zero", 3, 0, 8'h77, 1);
    chk("t5_zero_writes", wr_cnt - base_wr, 0);
    start_op(1'b1, 3, 0);
    chk("t5_zd_done", Done, 1);
    chk("t5_zd_ov", OutValid, 0);
    tick();
    base_wr = wr_cnt;
    do_load("t5_sat", 7, 20, 8'h40, 1);
    chk("t5_sat_writes", wr_cnt - base_wr, 16);
    push_dump(0, 16);
    OutReady = 1'b1;
    base_hs = hs_cnt;
    start_op(1'b1, 0, 20);
    wait_done("t5_sat_dump_done", 40);
    tick();
    chk("t5_sat_beats", hs_cnt - base_hs, 16);

    // Reset during dump of 5 after two handshakes.
    push_dump(7, 5);
    OutReady = 1'b1;
    base_cnt = done_cnt; base_hs = hs_cnt;
    start_op(1'b1, 7, 5);
    tick(); tick(); tick();
    chk("t6_two_beats", hs_cnt - base_hs, 2);
    Reset_n = 1'b0;
    tick();
    check_reset("t6");
    exp_rd.delete();
    Reset_n = 1'b1;
    tick(); tick();
    chk("t6_no_done", done_cnt - base_cnt, 0);
    push_dump(0, 2);
    base_cnt = done_cnt;
    start_op(1'b1, 0, 2);
    wait_done("t6_restart_done", 12);
    tick();
    chk("t6_restart_left", exp_rd.size(), 0);
    chk("t6_restart_done_cnt", done_cnt - base_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
